// File: rtl/cache_bus_arbiter_if.sv
// rtl/cache_bus_arbiter_if.sv - requester-side port of the cache bus arbiter
// One instance per master; the arbiter takes two of them on its slave modport.
interface cache_bus_arbiter_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADR_WIDTH  = 16
);
  logic                  rd;
  logic                  wr;
  logic [ADR_WIDTH-1:0]  address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  ready;

  modport master (output rd, wr, address, wdata, input rdata, ready);
  modport slave  (input rd, wr, address, wdata, output rdata, ready);
endinterface

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - two-master round-robin arbiter in front of the cache CPU port
// Optional watchdog abort of a stuck transaction is built when ARB_TIMEOUT_EN is defined.
module cache_bus_arbiter #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADR_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  cache_bus_arbiter_if.slave    m0,
  cache_bus_arbiter_if.slave    m1,
  output logic [ADR_WIDTH-1:0]  address_bus,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  output logic                  rd,
  output logic                  wr,
  input  logic                  ready,
  output logic                  grant,
  output logic                  err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;

  state_t                state_q, state_d;
  logic                  rd_q, wr_q, grant_q, rr_q;
  logic [ADR_WIDTH-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] wdata_q, m0_rdata_q, m1_rdata_q;
  logic                  m0_ready_q, m1_ready_q;

  logic                  req0, req1, sel, load, done, abort, tmo_hit;
  logic                  sel_rd, sel_wr;
  logic [ADR_WIDTH-1:0]  sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  assign req0      = m0.rd | m0.wr;
  assign req1      = m1.rd | m1.wr;
  assign sel_rd    = sel ? m1.rd      : m0.rd;
  assign sel_wr    = sel ? m1.wr      : m0.wr;
  assign sel_addr  = sel ? m1.address : m0.address;
  assign sel_wdata = sel ? m1.wdata   : m0.wdata;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic        err_q;

  // The counter value equals completed BUSY cycles, so the limit hits on the last allowed one.
  assign tmo_hit = (tmo_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= abort;
      if (load) begin
        tmo_cnt_q <= '0;
      end else if (state_q == S_BUSY) begin
        tmo_cnt_q <= tmo_cnt_q + 16'd1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit            = 1'b0;
  assign err                = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sel     = 1'b0;
    load    = 1'b0;
    done    = 1'b0;
    abort   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          sel     = (req0 & req1) ? rr_q : req1;
          load    = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (ready) begin
          done    = 1'b1;
          state_d = S_RELEASE;
        end else if (tmo_hit) begin
          abort   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      // A ready still high from the finished access must not count as a new completion.
      S_RELEASE: begin
        if (!ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      grant_q    <= 1'b0;
      rr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m0_ready_q <= done & ~grant_q;
      m1_ready_q <= done & grant_q;
      if (load) begin
        grant_q <= sel;
        wr_q    <= sel_wr;
        rd_q    <= sel_rd & ~sel_wr;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (done | abort) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
        rr_q <= ~grant_q;
      end
      if (done & rd_q) begin
        if (grant_q) begin
          m1_rdata_q <= data_bus;
        end else begin
          m0_rdata_q <= data_bus;
        end
      end
    end
  end

  assign rd          = rd_q;
  assign wr          = wr_q;
  assign grant       = grant_q;
  assign address_bus = (rd_q | wr_q) ? addr_q : {ADR_WIDTH{1'bz}};
  assign data_bus    = wr_q ? wdata_q : {DATA_WIDTH{1'bz}};

  assign m0.rdata = m0_rdata_q;
  assign m0.ready = m0_ready_q;
  assign m1.rdata = m1_rdata_q;
  assign m1.ready = m1_ready_q;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - directed self-checking bench for cache_bus_arbiter
// The timeout scenario runs only when ARB_TIMEOUT_EN is defined.
module tb_cache_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd, wr, ready, grant, err;
  wire  [15:0] address_bus;
  wire  [15:0] data_bus;
  logic        cache_drive = 1'b0;
  logic [15:0] cache_data  = 16'h0;

  int total = 0;
  int bad   = 0;
  int m0_pulses = 0;
  int m1_pulses = 0;
  int err_pulses = 0;
  logic was_active = 1'b0;
  logic glog[$];

  cache_bus_arbiter_if #(.DATA_WIDTH(16), .ADR_WIDTH(16)) m0_bus ();
  cache_bus_arbiter_if #(.DATA_WIDTH(16), .ADR_WIDTH(16)) m1_bus ();

  assign data_bus = cache_drive ? cache_data : 16'hzzzz;

  cache_bus_arbiter #(.DATA_WIDTH(16), .ADR_WIDTH(16), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .m0          (m0_bus),
    .m1          (m1_bus),
    .address_bus (address_bus),
    .data_bus    (data_bus),
    .rd          (rd),
    .wr          (wr),
    .ready       (ready),
    .grant       (grant),
    .err         (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (m0_bus.ready) m0_pulses <= m0_pulses + 1;
    if (m1_bus.ready) m1_pulses <= m1_pulses + 1;
    if (err) err_pulses <= err_pulses + 1;
    if ((rd | wr) && !was_active) glog.push_back(grant);
    was_active <= rd | wr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wait_active(input string tag);
    int n = 0;
    while (!(rd | wr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(rd | wr), 32'd1);
  endtask

  task automatic serve(input int delay, input int hold, input logic [15:0] rdat);
    wait_active("serve_start");
    repeat (delay) @(negedge clk);
    cache_drive = rd;
    cache_data  = rdat;
    ready       = 1'b1;
    repeat (hold) @(negedge clk);
    ready       = 1'b0;
    cache_drive = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int p0, p1, pe, n;
    logic owner;
    logic [15:0] d;

    ready = 1'b0;
    m0_bus.rd = 1'b1; m0_bus.wr = 1'b0; m0_bus.address = 16'd5; m0_bus.wdata = 16'h0;
    m1_bus.rd = 1'b0; m1_bus.wr = 1'b0; m1_bus.address = 16'd0; m1_bus.wdata = 16'h0;

    // reset held with a pending M0 read
    repeat (3) @(negedge clk);
    check("rst_rd", rd, 0);
    check("rst_wr", wr, 0);
    check("rst_m0_ready", m0_bus.ready, 0);
    check("rst_m1_ready", m1_bus.ready, 0);
    check("rst_grant", grant, 0);
    check("rst_err", err, 0);
    check("rst_m0_rdata", m0_bus.rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    check("first_rd", rd, 1);
    check("first_grant", grant, 0);
    check("first_addr", address_bus, 16'd5);

    // M0 read, cache answers after 4 cycles
    p0 = m0_pulses; p1 = m1_pulses;
    serve(4, 1, 16'h1234);
    m0_bus.rd = 1'b0;
    check("rd_m0_rdata", m0_bus.rdata, 16'h1234);
    check("rd_m0_pulse", m0_pulses - p0, 1);
    check("rd_m1_pulse", m1_pulses - p1, 0);

    // both masters contend continuously
    do_reset();
    m0_bus.rd = 1'b1; m0_bus.address = 16'd100;
    m1_bus.rd = 1'b1; m1_bus.address = 16'd200;
    glog.delete();
    for (int i = 0; i < 4; i++) begin
      p0 = m0_pulses; p1 = m1_pulses;
      d = 16'h1000 + 16'(i);
      owner = (i % 2) == 1;
      serve(1, 1, d);
      check("rr_log_len", glog.size(), i + 1);
      if (glog.size() > i) check("rr_grant", glog[i], owner);
      check("rr_m0_pulse", m0_pulses - p0, owner ? 0 : 1);
      check("rr_m1_pulse", m1_pulses - p1, owner ? 1 : 0);
      check("rr_rdata", owner ? m1_bus.rdata : m0_bus.rdata, d);
    end
    m0_bus.rd = 1'b0;
    m1_bus.rd = 1'b0;

    // M1 write with a sticky ready; M0 waits for it to fall
    @(negedge clk);
    m1_bus.wr = 1'b1; m1_bus.address = 16'd512; m1_bus.wdata = 16'hBEEF;
    wait_active("wr_start");
    check("wr_wr", wr, 1);
    check("wr_grant", grant, 1);
    check("wr_addr", address_bus, 16'd512);
    check("wr_data_bus", data_bus, 16'hBEEF);
    p1 = m1_pulses;
    repeat (2) @(negedge clk);
    check("wr_data_held", data_bus, 16'hBEEF);
    ready = 1'b1;
    @(negedge clk);
    m1_bus.wr = 1'b0;
    m0_bus.rd = 1'b1; m0_bus.address = 16'd7;
    repeat (2) @(negedge clk);
    check("wr_stale_ready_rd", rd, 0);
    check("wr_m1_pulse", m1_pulses - p1, 1);
    ready = 1'b0;
    @(negedge clk);
    check("wr_turnaround_rd", rd, 0);
    @(negedge clk);
    check("wr_next_rd", rd, 1);
    check("wr_next_grant", grant, 0);
    serve(1, 1, 16'hAAAA);
    m0_bus.rd = 1'b0;
    check("wr_next_rdata", m0_bus.rdata, 16'hAAAA);

    // reset in the middle of a read
    @(negedge clk);
    m0_bus.rd = 1'b1; m0_bus.address = 16'd9;
    wait_active("mid_rst_start");
    p0 = m0_pulses;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_rd", rd, 0);
    check("mid_rst_m0_ready", m0_bus.ready, 0);
    check("mid_rst_rdata", m0_bus.rdata, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_no_pulse", m0_pulses - p0, 0);
    serve(2, 1, 16'h5A5A);
    m0_bus.rd = 1'b0;
    check("mid_rst_redo_rdata", m0_bus.rdata, 16'h5A5A);
    check("mid_rst_redo_pulse", m0_pulses - p0, 1);

`ifdef ARB_TIMEOUT_EN
    // cache never answers; M1 is pending behind M0
    do_reset();
    m0_bus.rd = 1'b1; m0_bus.address = 16'd33;
    m1_bus.rd = 1'b1; m1_bus.address = 16'd44;
    wait_active("tmo_start");
    check("tmo_first_grant", grant, 0);
    p0 = m0_pulses; p1 = m1_pulses; pe = err_pulses;
    n = 0;
    while (rd && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("tmo_busy_cycles", n, 8);
    check("tmo_err", err, 1);
    m0_bus.rd = 1'b0;
    @(negedge clk);
    check("tmo_err_one_cycle", err, 0);
    wait_active("tmo_next_start");
    check("tmo_next_grant", grant, 1);
    check("tmo_err_count", err_pulses - pe, 1);
    check("tmo_no_m0_pulse", m0_pulses - p0, 0);
    check("tmo_no_m1_pulse", m1_pulses - p1, 0);
    serve(1, 1, 16'h0F0F);
    m1_bus.rd = 1'b0;
    check("tmo_m1_rdata", m1_bus.rdata, 16'h0F0F);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
